tri_cmd_loader: RTL and testbench

TRI_CMD_LOADER -- requirements
Module: tri_cmd_loader

---
 rtl/tri_cmd_loader.sv | 189 ++++++++++++++++++
 tb/tb_tri_cmd_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tri_cmd_loader.sv
// Triangle command loader: UART byte packets -> staging -> shadow -> active (swapped on frame_start).
// Optional trailing XOR checksum byte enabled by defining TRI_CKSUM_EN.
module tri_cmd_loader #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               frame_start,
  output logic signed [19:0] x_screen_v0,
  output logic signed [19:0] y_screen_v0,
  output logic signed [19:0] x_screen_v1,
  output logic signed [19:0] y_screen_v1,
  output logic signed [19:0] x_screen_v2,
  output logic signed [19:0] y_screen_v2,
  output logic [5:0]         tri_color,
  output logic               tri_valid,
  output logic               pending,
  output logic               commit,
  output logic               err,
  output logic               busy
);

`ifdef TRI_CKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHK} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_PAYLOAD} state_t;
`endif

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         stg_q [0:12];
  logic [7:0]         stg_d [0:12];
  logic               done_q, done_d;
  logic signed [19:0] shx_q [0:5];
  logic signed [19:0] shx_d [0:5];
  logic [5:0]         shc_q, shc_d;
  logic               pend_q, pend_d;
  logic signed [19:0] act_q [0:5];
  logic signed [19:0] act_d [0:5];
  logic [5:0]         actc_q, actc_d;
  logic               valid_q, valid_d;
  logic               commit_q, commit_d;
  logic               err_q, err_d;
`ifdef TRI_CKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stg_d    = stg_q;
    done_d   = 1'b0;
    shx_d    = shx_q;
    shc_d    = shc_q;
    pend_d   = pend_q;
    act_d    = act_q;
    actc_d   = actc_q;
    valid_d  = valid_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
`ifdef TRI_CKSUM_EN
    xor_d    = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_valid && rx_data == HDR_BYTE) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
`ifdef TRI_CKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          cnt_d        = '0;
          stg_d[idx_q] = rx_data;
          idx_d        = idx_q + 4'd1;
`ifdef TRI_CKSUM_EN
          xor_d        = xor_q ^ rx_data;
          if (idx_q == 4'd12) state_d = S_CHK;
`else
          if (idx_q == 4'd12) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef TRI_CKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_data == xor_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Commit reads the old shadow before a same-cycle load overwrites it, so pending ends up set.
    if (frame_start && pend_q) begin
      act_d    = shx_q;
      actc_d   = shc_q;
      commit_d = 1'b1;
      valid_d  = 1'b1;
      pend_d   = 1'b0;
    end
    if (done_q) begin
      for (int unsigned i = 0; i < 6; i++)
        shx_d[i] = {{4{stg_q[2*i+1][7]}}, stg_q[2*i+1], stg_q[2*i]};
      shc_d  = stg_q[12][5:0];
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      stg_q    <= '{default: '0};
      done_q   <= 1'b0;
      shx_q    <= '{default: '0};
      shc_q    <= '0;
      pend_q   <= 1'b0;
      act_q    <= '{default: '0};
      actc_q   <= '0;
      valid_q  <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef TRI_CKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      stg_q    <= stg_d;
      done_q   <= done_d;
      shx_q    <= shx_d;
      shc_q    <= shc_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      actc_q   <= actc_d;
      valid_q  <= valid_d;
      commit_q <= commit_d;
      err_q    <= err_d;
`ifdef TRI_CKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign x_screen_v0 = act_q[0];
  assign y_screen_v0 = act_q[1];
  assign x_screen_v1 = act_q[2];
  assign y_screen_v1 = act_q[3];
  assign x_screen_v2 = act_q[4];
  assign y_screen_v2 = act_q[5];
  assign tri_color   = actc_q;
  assign tri_valid   = valid_q;
  assign pending     = pend_q;
  assign commit      = commit_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_tri_cmd_loader.sv
// Bench for tri_cmd_loader: packet-level model checked every cycle plus literal pins.
module tb_tri_cmd_loader;
  localparam logic [15:0] TO  = 16'd20;
  localparam logic [7:0]  HDR = 8'hA5;
`ifdef TRI_CKSUM_EN
  localparam int PLEN = 14;
`else
  localparam int PLEN = 13;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] rx_data;
  logic rx_valid, frame_start;
  logic signed [19:0] xv0, yv0, xv1, yv1, xv2, yv2;
  logic [5:0] tri_color;
  logic tri_valid, pending, commit, err, busy;

  tri_cmd_loader #(.TIMEOUT_CYC(TO), .HDR_BYTE(HDR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_start(frame_start),
    .x_screen_v0(xv0), .y_screen_v0(yv0), .x_screen_v1(xv1),
    .y_screen_v1(yv1), .x_screen_v2(xv2), .y_screen_v2(yv2),
    .tri_color(tri_color), .tri_valid(tri_valid), .pending(pending),
    .commit(commit), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Packet-level reference model.
  bit                 m_in_pkt, m_load, m_pend, m_valid, m_commit, m_err;
  int                 m_idle;
  logic [7:0]         m_q[$];
  logic [7:0]         m_buf[$];
  logic signed [19:0] m_sh[6], m_act[6];
  logic [5:0]         m_shc, m_actc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_pkt = 0; m_load = 0; m_pend = 0; m_valid = 0; m_commit = 0; m_err = 0;
      m_idle = 0; m_q.delete(); m_buf.delete();
      for (int i = 0; i < 6; i++) begin m_sh[i] = '0; m_act[i] = '0; end
      m_shc = '0; m_actc = '0;
    end else begin
      m_commit = 0; m_err = 0;
      if (frame_start && m_pend) begin
        m_act = m_sh; m_actc = m_shc; m_commit = 1; m_valid = 1; m_pend = 0;
      end
      if (m_load) begin
        for (int i = 0; i < 6; i++) begin
          logic signed [15:0] w;
          w = {m_buf[2*i+1], m_buf[2*i]};
          m_sh[i] = w;
        end
        m_shc = m_buf[12][5:0];
        m_pend = 1; m_load = 0;
      end
      if (!m_in_pkt) begin
        if (rx_valid && rx_data == HDR) begin m_in_pkt = 1; m_q.delete(); m_idle = 0; end
      end else if (rx_valid) begin
        m_q.push_back(rx_data);
        m_idle = 0;
        if (m_q.size() == PLEN) begin
          logic [7:0] x;
          x = '0;
          for (int i = 0; i < 13; i++) x ^= m_q[i];
          if (PLEN == 13 || x == m_q[PLEN-1]) begin m_load = 1; m_buf = m_q; end
          else m_err = 1;
          m_in_pkt = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == int'(TO)) begin m_err = 1; m_in_pkt = 0; end
      end
    end
  end

  always @(negedge clk) begin
    check("commit", {19'd0, commit}, {19'd0, m_commit});
    check("err", {19'd0, err}, {19'd0, m_err});
    check("pending", {19'd0, pending}, {19'd0, m_pend});
    check("tri_valid", {19'd0, tri_valid}, {19'd0, m_valid});
    check("busy", {19'd0, busy}, {19'd0, m_in_pkt});
    check("tri_color", {14'd0, tri_color}, {14'd0, m_actc});
    check("x_v0", xv0, m_act[0]);
    check("y_v0", yv0, m_act[1]);
    check("x_v1", xv1, m_act[2]);
    check("y_v1", yv1, m_act[3]);
    check("x_v2", xv2, m_act[4]);
    check("y_v2", yv2, m_act[5]);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fs);
    rx_data = b; rx_valid = 1'b1; frame_start = fs;
    step(1);
    rx_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  // fs_mode: 0 none, 1 frame_start with last byte, 2 frame_start the cycle after.
  task automatic send_pkt(input logic [15:0] c0, c1, c2, c3, c4, c5,
                          input logic [7:0] col, input bit bad_ck, input int fs_mode);
    logic [7:0] b[14];
    logic [15:0] c[6];
    logic [7:0] x;
    c = '{c0, c1, c2, c3, c4, c5};
    x = '0;
    for (int i = 0; i < 6; i++) begin b[2*i] = c[i][7:0]; b[2*i+1] = c[i][15:8]; end
    b[12] = col;
    for (int i = 0; i < 13; i++) x ^= b[i];
    b[13] = bad_ck ? ~x : x;
    send_byte(HDR, 1'b0);
    for (int i = 0; i < PLEN; i++) send_byte(b[i], (fs_mode == 1) && (i == PLEN - 1));
    if (fs_mode == 2) frame();
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; frame_start = 1'b0;
    step(3);
    check("rst_x_v0", xv0, 20'd0);
    check("rst_pending", {19'd0, pending}, 20'd0);
    check("rst_busy", {19'd0, busy}, 20'd0);
    rst_n = 1'b1;
    step(2);
    send_byte(8'h37, 1'b0);          // non-header byte ignored
    check("ignored_busy", {19'd0, busy}, 20'd0);

    send_pkt(16'h0140, 16'h0010, 16'h0020, 16'h01C0, 16'h0260, 16'h01C0, 8'h30, 0, 0);
    step(2);
    check("pend_before_frame", {19'd0, pending}, 20'd1);
    check("valid_before_frame", {19'd0, tri_valid}, 20'd0);
    frame();
    check("pin_commit", {19'd0, commit}, 20'd1);
    check("pin_x_v0", xv0, 20'd320);
    check("pin_y_v1", yv1, 20'd448);
    check("pin_color", {14'd0, tri_color}, 20'h30);
    check("pin_valid", {19'd0, tri_valid}, 20'd1);
    check("pin_pending", {19'd0, pending}, 20'd0);
    step(1);
    check("commit_pulse_end", {19'd0, commit}, 20'd0);

    send_pkt(16'hFFF6, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 8'h15, 0, 0);
    step(1);
    frame();
    check("pin_neg_x_v0", xv0, 20'hFFFF6);

`ifdef TRI_CKSUM_EN
    send_pkt(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 8'h2A, 1, 0);
    check("pin_ck_err", {19'd0, err}, 20'd1);
    step(1);
    check("pin_ck_err_end", {19'd0, err}, 20'd0);
    frame();
    check("pin_ck_no_commit", {19'd0, commit}, 20'd0);
    check("pin_ck_active", xv0, 20'hFFFF6);
`endif

    send_byte(HDR, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
    step(int'(TO) - 1);
    check("pin_to_not_yet", {19'd0, err}, 20'd0);
    step(1);
    check("pin_to_err", {19'd0, err}, 20'd1);
    check("pin_to_busy", {19'd0, busy}, 20'd0);
    send_pkt(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 8'h07, 0, 0);
    step(1);
    frame();
    check("pin_after_to", xv0, 20'h00011);

    send_pkt(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 8'h03, 0, 0);
    send_pkt(16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 8'h0C, 0, 0);
    step(1);
    frame();
    check("pin_latest_color", {14'd0, tri_color}, 20'h0C);
    frame();
    check("pin_single_commit", {19'd0, commit}, 20'd0);

    send_pkt(16'h0010, 16'h00A5, 16'h00A5, 16'h0010, 16'h0010, 16'h0010, 8'h21, 0, 1);
    check("pin_last_fs_no_commit", {19'd0, commit}, 20'd0);
    step(1);
    frame();
    check("pin_last_fs_later", {14'd0, tri_color}, 20'h21);
    check("pin_hdr_data", yv0, 20'h000A5);

    send_pkt(16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 8'h11, 0, 0);
    send_pkt(16'h0006, 16'h0006, 16'h0006, 16'h0006, 16'h0006, 16'h0006, 8'h12, 0, 2);
    check("pin_same_cyc_color", {14'd0, tri_color}, 20'h11);
    check("pin_same_cyc_pend", {19'd0, pending}, 20'd1);
    frame();
    check("pin_same_cyc_next", {14'd0, tri_color}, 20'h12);

    send_byte(HDR, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h44, 1'b0);
    rst_n = 1'b0;
    step(1);
    check("pin_midrst_err", {19'd0, err}, 20'd0);
    check("pin_midrst_busy", {19'd0, busy}, 20'd0);
    check("pin_midrst_color", {14'd0, tri_color}, 20'd0);
    rst_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
